layer_cmd_sequencer: RTL and testbench

Host-side command front end for `cnn_layer_accel`, in the `clk_intf` domain directly upstream of the accelerator. Assembles 32-bit host writes into 128-bit layer descriptors and buffers them in a small FIFO. Issues them one at a time to the accelerator with a start/done handshake, counting completed layers and flagging protocol errors and timeouts.

---
 rtl/layer_seq_pkg.sv | 26 ++
 rtl/layer_cmd_sequencer_desc_fifo.sv | 66 ++++++
 rtl/layer_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_layer_cmd_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the layer command sequencer.
// Holds the sequencer FSM state type, the layer descriptor layout and the
// nominal descriptor width. No ports.
package layer_seq_pkg;

  localparam int DESC_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } seq_state_t;

  // The named fields fill all 128 descriptor bits exactly, so no bits are
  // left over for a reserved field.
  typedef struct packed {
    logic [7:0]  layer_id;
    logic [15:0] num_rows;
    logic [15:0] num_cols;
    logic [15:0] num_kernels;
    logic [7:0]  kernel_size;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } layer_desc_t;

endpackage

// File: rtl/layer_cmd_sequencer_desc_fifo.sv
// desc_fifo: synchronous first-word-fall-through FIFO for layer descriptors.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_data   write request (ignored when full)
//   pop,  pop_data    read request (ignored when empty); pop_data shows head
//   full, empty       status flags
//   level             number of stored entries (registered)
module desc_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits match.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array carries no reset; stale entries are never visible because
  // the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/layer_cmd_sequencer.sv
// layer_cmd_sequencer: host-side command front end for the CNN layer
// accelerator. Packs host words into descriptors, queues them, and launches
// them one at a time with a start/done handshake.
// Ports:
//   clk_intf, rst                   clock, synchronous active-high reset
//   host_wr_valid/data/ready        host word write channel
//   accel_desc, accel_start         descriptor and one-cycle launch pulse
//   accel_done                      one-cycle completion pulse
//   layers_done                     completed-layer counter (wraps)
//   fifo_level                      descriptors waiting in the queue
//   seq_idle                        nothing running and nothing queued
//   err_proto, err_timeout          sticky error flags
module layer_cmd_sequencer #(
  parameter int DATA_W      = 32,
  parameter int DESC_WORDS  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic                           clk_intf,
  input  logic                           rst,
  input  logic                           host_wr_valid,
  input  logic [DATA_W-1:0]              host_wr_data,
  output logic                           host_wr_ready,
  output logic [DATA_W*DESC_WORDS-1:0]   accel_desc,
  output logic                           accel_start,
  input  logic                           accel_done,
  output logic [15:0]                    layers_done,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           seq_idle,
  output logic                           err_proto,
  output logic                           err_timeout
);

  import layer_seq_pkg::*;

  localparam int DESC_BITS = DATA_W * DESC_WORDS;
  localparam int CNT_W     = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DESC_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  seq_state_t           state;
  logic [CNT_W-1:0]     word_cnt;
  logic [DESC_BITS-1:0] asm_desc;
  logic [DESC_BITS-1:0] asm_next;
  logic [DESC_BITS-1:0] head_desc;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 word_accept;
  logic                 push;
  logic                 pop;

  assign host_wr_ready = !fifo_full;
  assign word_accept   = host_wr_valid && host_wr_ready;
  assign push          = word_accept && (word_cnt == LAST_WORD);
  assign pop           = (state == IDLE) && !fifo_empty;
  assign seq_idle      = (state == IDLE) && fifo_empty;

  // The incoming word is merged into the partial descriptor here so that the
  // final word can be pushed in the same cycle it arrives.
  always_comb begin
    asm_next = asm_desc;
    asm_next[int'(word_cnt)*DATA_W +: DATA_W] = host_wr_data;
  end

  // Word assembly; a partial descriptor simply waits while the FIFO is full.
  always_ff @(posedge clk_intf) begin
    if (rst) begin
      word_cnt <= '0;
      asm_desc <= '0;
    end else if (word_accept) begin
      asm_desc <= asm_next;
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CNT_ONE;
    end
  end

  desc_fifo #(
    .WIDTH (DESC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_intf),
    .rst       (rst),
    .push      (push),
    .push_data (asm_next),
    .pop       (pop),
    .pop_data  (head_desc),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Launch sequencing. The head descriptor is latched as the FSM leaves IDLE
  // and stays put until the next launch. In RUN, a done pulse on the same
  // edge as the timeout takes priority and counts as a completed layer.
  always_ff @(posedge clk_intf) begin
    if (rst) begin
      state       <= IDLE;
      accel_start <= 1'b0;
      accel_desc  <= '0;
      layers_done <= '0;
      tmo_cnt     <= '0;
      err_proto   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      accel_start <= 1'b0;
      if (accel_done && (state != RUN)) begin
        err_proto <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= LAUNCH;
            accel_desc  <= head_desc;
            accel_start <= 1'b1;
          end
        end
        LAUNCH: begin
          state   <= RUN;
          tmo_cnt <= '0;
        end
        RUN: begin
          if (accel_done) begin
            state       <= IDLE;
            layers_done <= layers_done + 16'd1;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_cmd_sequencer.sv
// Testbench for layer_cmd_sequencer: directed scenarios plus a randomized
// stream checked against a queue-based model of descriptor order and count.
module tb_layer_cmd_sequencer;

  localparam int DATA_W      = 32;
  localparam int DESC_WORDS  = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int DESC_BITS   = DATA_W * DESC_WORDS;

  logic                 clk_intf = 1'b0;
  logic                 rst = 1'b1;
  logic                 host_wr_valid = 1'b0;
  logic [DATA_W-1:0]    host_wr_data = '0;
  logic                 host_wr_ready;
  logic [DESC_BITS-1:0] accel_desc;
  logic                 accel_start;
  logic                 accel_done = 1'b0;
  logic [15:0]          layers_done;
  logic [2:0]           fifo_level;
  logic                 seq_idle;
  logic                 err_proto;
  logic                 err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_layers   = 0;
  logic [DESC_BITS-1:0] start_q[$];

  layer_cmd_sequencer #(
    .DATA_W      (DATA_W),
    .DESC_WORDS  (DESC_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_intf      (clk_intf),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_ready (host_wr_ready),
    .accel_desc    (accel_desc),
    .accel_start   (accel_start),
    .accel_done    (accel_done),
    .layers_done   (layers_done),
    .fifo_level    (fifo_level),
    .seq_idle      (seq_idle),
    .err_proto     (err_proto),
    .err_timeout   (err_timeout)
  );

  always #5 clk_intf = ~clk_intf;

  // Record the descriptor presented with every launch pulse.
  always @(posedge clk_intf) begin
    #1;
    if (accel_start === 1'b1) start_q.push_back(accel_desc);
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk_intf);
    #1;
  endtask

  task automatic write_desc(input logic [DESC_BITS-1:0] d);
    for (int i = 0; i < DESC_WORDS; i++) begin
      int n = 0;
      host_wr_valid = 1'b1;
      host_wr_data  = d[i*DATA_W +: DATA_W];
      while (host_wr_ready !== 1'b1 && n < 200) begin step(); n++; end
      if (n >= 200) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL wr_ready_wait: ready=%b after %0d cycles, required 1", host_wr_ready, n);
      end
      step();
    end
    host_wr_valid = 1'b0;
  endtask

  task automatic pulse_done();
    accel_done = 1'b1;
    step();
    accel_done = 1'b0;
  endtask

  task automatic wait_start(input int limit);
    int n = 0;
    while (accel_start !== 1'b1 && n < limit) begin step(); n++; end
    if (n >= limit) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL start_wait: no accel_start within %0d cycles", limit);
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if (host_wr_ready !== 1'b1 || accel_start !== 1'b0 || accel_desc !== '0 ||
        layers_done !== 16'd0 || fifo_level !== 3'd0 || seq_idle !== 1'b1 ||
        err_proto !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: rdy=%b start=%b desc=%h layers=%0d level=%0d idle=%b ep=%b et=%b, required 1 0 0 0 0 1 0 0",
               tag, host_wr_ready, accel_start, accel_desc, layers_done, fifo_level, seq_idle, err_proto, err_timeout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_values("reset_values");
    step();
    check_reset_values("post_reset_values");
    exp_layers = 0;
  endtask

  task automatic test_basic();
    start_q.delete();
    for (int i = 0; i < DESC_WORDS; i++) begin
      host_wr_valid = 1'b1;
      host_wr_data  = DATA_W'((i + 1) * 32'h11111111);
      step();
    end
    host_wr_valid = 1'b0;
    tests_run++;
    if (accel_start !== 1'b0 || fifo_level !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_edge_k: start=%b level=%0d, required 0 1", accel_start, fifo_level);
    end
    step();
    tests_run++;
    if (accel_start !== 1'b1 || accel_desc !== 128'h44444444_33333333_22222222_11111111 || fifo_level !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL basic_launch: start=%b desc=%h level=%0d, required 1 44444444333333332222222211111111 0",
               accel_start, accel_desc, fifo_level);
    end
    step();
    tests_run++;
    if (accel_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_start_width: start=%b, required 0", accel_start);
    end
    repeat (8) step();
    pulse_done();
    exp_layers++;
    tests_run++;
    if (layers_done !== 16'(exp_layers) || seq_idle !== 1'b1 || start_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: layers=%0d idle=%b starts=%0d, required %0d 1 1",
               layers_done, seq_idle, start_q.size(), exp_layers);
    end
  endtask

  task automatic test_fill();
    logic [DESC_BITS-1:0] exp_d[5];
    start_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      write_desc(exp_d[i]);
    end
    tests_run++;
    if (fifo_level !== 3'd4 || host_wr_ready !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: level=%0d ready=%b et=%b, required 4 0 0", fifo_level, host_wr_ready, err_timeout);
    end
    host_wr_valid = 1'b1;
    host_wr_data  = 32'hDEADBEEF;
    pulse_done();
    host_wr_valid = 1'b0;
    exp_layers++;
    tests_run++;
    if (fifo_level !== 3'd4 || layers_done !== 16'(exp_layers)) begin
      tests_failed++;
      $display("[TB] FAIL fill_blocked_push: level=%0d layers=%0d, required 4 %0d", fifo_level, layers_done, exp_layers);
    end
    for (int i = 1; i < 5; i++) begin
      wait_start(10);
      step();
      repeat ($urandom_range(0, 3)) step();
      pulse_done();
      exp_layers++;
    end
    repeat (3) step();
    tests_run++;
    if (start_q.size() != 5) begin
      tests_failed++;
      $display("[TB] FAIL fill_start_count: starts=%0d, required 5", start_q.size());
    end
    for (int i = 0; i < 5 && i < start_q.size(); i++) begin
      tests_run++;
      if (start_q[i] !== exp_d[i]) begin
        tests_failed++;
        $display("[TB] FAIL fill_order[%0d]: desc=%h, required %h", i, start_q[i], exp_d[i]);
      end
    end
    tests_run++;
    if (layers_done !== 16'(exp_layers) || seq_idle !== 1'b1 || err_proto !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fill_end: layers=%0d idle=%b ep=%b et=%b, required %0d 1 0 0",
               layers_done, seq_idle, err_proto, err_timeout, exp_layers);
    end
  endtask

  task automatic test_proto();
    tests_run++;
    if (err_proto !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL proto_before: err_proto=%b, required 0", err_proto);
    end
    pulse_done();
    step();
    tests_run++;
    if (err_proto !== 1'b1 || seq_idle !== 1'b1 || accel_start !== 1'b0 || layers_done !== 16'(exp_layers)) begin
      tests_failed++;
      $display("[TB] FAIL proto_idle_done: ep=%b idle=%b start=%b layers=%0d, required 1 1 0 %0d",
               err_proto, seq_idle, accel_start, layers_done, exp_layers);
    end
  endtask

  task automatic test_timeout();
    logic [DESC_BITS-1:0] da, db, dc;
    da = {$urandom(), $urandom(), $urandom(), $urandom()};
    db = {$urandom(), $urandom(), $urandom(), $urandom()};
    dc = {$urandom(), $urandom(), $urandom(), $urandom()};
    // done arriving on the final permitted RUN cycle still counts
    write_desc(da);
    step();
    tests_run++;
    if (accel_start !== 1'b1 || accel_desc !== da) begin
      tests_failed++;
      $display("[TB] FAIL tmo_launch_a: start=%b desc=%h, required 1 %h", accel_start, accel_desc, da);
    end
    step();
    repeat (TIMEOUT_CYC - 1) step();
    tests_run++;
    if (err_timeout !== 1'b0 || seq_idle !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tmo_early: et=%b idle=%b, required 0 0", err_timeout, seq_idle);
    end
    pulse_done();
    exp_layers++;
    tests_run++;
    if (err_timeout !== 1'b0 || layers_done !== 16'(exp_layers)) begin
      tests_failed++;
      $display("[TB] FAIL tmo_done_wins: et=%b layers=%0d, required 0 %0d", err_timeout, layers_done, exp_layers);
    end
    // now let a layer run out of time with another queued behind it
    write_desc(db);
    step();
    tests_run++;
    if (accel_start !== 1'b1 || accel_desc !== db) begin
      tests_failed++;
      $display("[TB] FAIL tmo_launch_b: start=%b desc=%h, required 1 %h", accel_start, accel_desc, db);
    end
    write_desc(dc);
    repeat (TIMEOUT_CYC - 4) step();
    tests_run++;
    if (err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tmo_cycle15: et=%b, required 0", err_timeout);
    end
    step();
    tests_run++;
    if (err_timeout !== 1'b1 || accel_start !== 1'b0 || layers_done !== 16'(exp_layers) || fifo_level !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL tmo_cycle16: et=%b start=%b layers=%0d level=%0d, required 1 0 %0d 1",
               err_timeout, accel_start, layers_done, fifo_level, exp_layers);
    end
    step();
    tests_run++;
    if (accel_start !== 1'b1 || accel_desc !== dc) begin
      tests_failed++;
      $display("[TB] FAIL tmo_next_launch: start=%b desc=%h, required 1 %h", accel_start, accel_desc, dc);
    end
    step();
    pulse_done();
    exp_layers++;
    tests_run++;
    if (layers_done !== 16'(exp_layers) || err_timeout !== 1'b1 || seq_idle !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL tmo_after: layers=%0d et=%b idle=%b, required %0d 1 1", layers_done, err_timeout, seq_idle, exp_layers);
    end
  endtask

  task automatic test_reset_mid();
    logic [DESC_BITS-1:0] dn;
    dn = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_q.delete();
    host_wr_valid = 1'b1;
    host_wr_data  = 32'hAAAA0000;
    step();
    host_wr_data  = 32'hBBBB1111;
    step();
    host_wr_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_layers = 0;
    check_reset_values("midreset_values");
    write_desc(dn);
    step();
    step();
    pulse_done();
    exp_layers++;
    repeat (4) step();
    tests_run++;
    if (start_q.size() != 1 || layers_done !== 16'(exp_layers)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_count: starts=%0d layers=%0d, required 1 %0d", start_q.size(), layers_done, exp_layers);
    end else begin
      tests_run++;
      if (start_q[0] !== dn) begin
        tests_failed++;
        $display("[TB] FAIL midreset_desc: desc=%h, required %h", start_q[0], dn);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 8;
    logic [DESC_BITS-1:0] exp_q[$];
    start_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    fork
      begin
        for (int i = 0; i < N; i++) begin
          for (int w = 0; w < DESC_WORDS; w++) begin
            int n = 0;
            repeat ($urandom_range(0, 3)) step();
            host_wr_valid = 1'b1;
            host_wr_data  = exp_q[i][w*DATA_W +: DATA_W];
            while (host_wr_ready !== 1'b1 && n < 300) begin step(); n++; end
            step();
            host_wr_valid = 1'b0;
          end
        end
      end
      begin
        for (int i = 0; i < N; i++) begin
          wait_start(300);
          step();
          repeat ($urandom_range(0, 10)) step();
          pulse_done();
        end
      end
    join
    exp_layers += N;
    repeat (3) step();
    tests_run++;
    if (start_q.size() != N) begin
      tests_failed++;
      $display("[TB] FAIL rand_start_count: starts=%0d, required %0d", start_q.size(), N);
    end
    for (int i = 0; i < N && i < start_q.size(); i++) begin
      tests_run++;
      if (start_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL rand_order[%0d]: desc=%h, required %h", i, start_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (layers_done !== 16'(exp_layers) || seq_idle !== 1'b1 || fifo_level !== 3'd0 ||
        err_proto !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rand_end: layers=%0d idle=%b level=%0d ep=%b et=%b, required %0d 1 0 0 0",
               layers_done, seq_idle, fifo_level, err_proto, err_timeout, exp_layers);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_proto();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
